td4_decode_stage: RTL
=====================

Name: td4_decode_stage

Overview:
Registered, parametrised instruction-decode pipeline stage placed between fetch and execute in the TD4-family CPU.
- Accepts instruction words over a valid/ready handshake and decodes the 4-bit opcode field into the lib_cpu OPECODE enum.
- Extracts an IMM_W-bit immediate and provides full throughput under back-pressure via a 2-entry skid buffer.
- Supports synchronous flush for taken jumps and keeps saturating decode/illegal-instruction counters.

Parameters:
- IMM_W, 4, immediate field width; instruction word width is IMM_W+4.
- CNT_W, 16, width of the decode and illegal counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept an instruction.
- in_insn  input  IMM_W+4  instruction word; opcode = [IMM_W+3:IMM_W], imm = [IMM_W-1:0].
- flush  input  1  synchronous discard of all held instructions.
- out_valid  output  1  decoded instruction available.
- out_ready  input  1  execute consumes the output.
- out_opcode  output  OPECODE  decoded operation.
- out_imm  output  IMM_W  immediate.
- insn_count  output  CNT_W  saturating count of output handshakes.
- illegal_count  output  CNT_W  saturating count of output handshakes carrying INVALID.

Behaviour:
- Reset values: out_valid=0, out_opcode=INVALID, out_imm=0, skid empty, both counters 0. in_ready is 1 once reset is released.
- Opcode map (field value -> enum):
  - 0000 ADD_A_IMM, 0101 ADD_B_IMM, 0011 MOV_A_IMM, 0111 MOV_B_IMM
  - 0001 MOV_A_B, 0100 MOV_B_A
  - 1111 JMP_IMM, 1110 JNC_IMM
  - 0010 IN_A, 0110 IN_B
  - 1001 OUT_B, 1011 OUT_IMM
  - all others INVALID
- Decode is combinational on in_insn; the result is registered.
- Latency: 1 cycle from input handshake to out_valid when the stage is empty.
- Storage: output register (O) plus skid register (S), each with its own valid bit.
- in_ready = !S.valid, gated by the trap flag when the optional feature is built in. It is combinational from registered state only, with no path from out_ready.
- Input handshake (in_valid && in_ready):
  - If !O.valid or out_ready: the decoded word loads O.
  - Otherwise: the decoded word loads S.
- Output handshake (out_valid && out_ready):
  - If S.valid: S moves to O and S is cleared.
  - Else if there is no simultaneous input: O.valid clears.
- Ordering is strictly in order. An input is never dropped and never duplicated.
- Simultaneous output handshake, input handshake and full S cannot occur, because in_ready=0 when S is full.
- flush=1:
  - Next cycle, O.valid=0 and S.valid=0.
  - Any input handshake in the same cycle is discarded.
  - An output handshake in the flush cycle still counts.
  - Flush has priority over every other update.
- Counters:
  - insn_count increments on each output handshake.
  - illegal_count increments on each output handshake whose opcode is INVALID.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - Flush does not clear the counters; only reset does.
- Asynchronous reset mid-operation clears all state immediately. No partial outputs remain after release.
- out_opcode and out_imm hold their value while out_valid && !out_ready.

Optional Feature:
- Macro TD4_DECODE_TRAP_EN.
- When defined:
  - Adds output port trap (1 bit, reset 0) and input port trap_clr (1 bit).
  - trap sets on an input handshake that decodes to INVALID. That instruction is still stored and delivered so it can be counted.
  - While trap=1, in_ready=0.
  - trap_clr=1 clears trap next cycle. flush also clears trap. Setting has priority over trap_clr in the same cycle.
- When undefined: no trap or trap_clr ports; INVALID passes through like any other opcode.

Test Plan:
- Reset then in_insn=0x35 (IMM_W=4) with out_ready=1 -> next cycle out_valid=1, out_opcode=MOV_A_IMM, out_imm=5, insn_count=1 after the handshake.
- Hold out_ready=0 and send 0x01, 0x52, 0xF3 back-to-back -> third word stalls (in_ready=0 after two accepts). Release out_ready -> outputs ADD_A_IMM/1, ADD_B_IMM/2, JMP_IMM/3 in order with no gaps.
- Send 0x80 and 0xC7 -> both are delivered as INVALID; illegal_count=2, insn_count=2.
- With O and S full, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, counters unchanged.
- CNT_W=2, run 5 output handshakes -> insn_count stays at 3.
- With TD4_DECODE_TRAP_EN, send 0xD0 -> trap=1 and in_ready=0 while INVALID is delivered. Pulse trap_clr -> trap=0 and in_ready=1 next cycle.

Source files
------------

// File: rtl/td4_decode_stage.sv
// td4_decode_stage -- registered decode stage between fetch and execute.
//
// Decodes the 4-bit opcode field of each incoming instruction into the
// lib_cpu OPECODE enum, extracts an IMM_W-bit immediate and registers the
// result. A second (skid) register absorbs one word of back-pressure so that
// in_ready depends only on registered state, never on out_ready.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  fetch handshake; in_insn = {opcode[3:0], imm[IMM_W-1:0]}
//   flush              synchronous discard of every held instruction
//   out_valid/out_ready execute handshake; out_opcode, out_imm
//   insn_count         saturating count of output handshakes
//   illegal_count      saturating count of output handshakes carrying INVALID
//
// Optional feature (macro TD4_DECODE_TRAP_EN):
//   adds output trap and input trap_clr; an accepted INVALID instruction sets
//   trap, which blocks further input until trap_clr or flush.

package lib_cpu;
    // Encodings match the opcode field wherever a mapping exists; INVALID
    // takes one of the unused field values.
    typedef enum logic [3:0] {
        ADD_A_IMM = 4'b0000,
        MOV_A_B   = 4'b0001,
        IN_A      = 4'b0010,
        MOV_A_IMM = 4'b0011,
        MOV_B_A   = 4'b0100,
        ADD_B_IMM = 4'b0101,
        IN_B      = 4'b0110,
        MOV_B_IMM = 4'b0111,
        INVALID   = 4'b1000,
        OUT_B     = 4'b1001,
        OUT_IMM   = 4'b1011,
        JNC_IMM   = 4'b1110,
        JMP_IMM   = 4'b1111
    } OPECODE;
endpackage

module td4_decode_stage
    import lib_cpu::*;
#(
    parameter int IMM_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W+3:0] in_insn,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output OPECODE           out_opcode,
    output logic [IMM_W-1:0] out_imm,
    output logic [CNT_W-1:0] insn_count,
`ifdef TD4_DECODE_TRAP_EN
    output logic [CNT_W-1:0] illegal_count,
    output logic             trap,
    input  logic             trap_clr
`else
    output logic [CNT_W-1:0] illegal_count
`endif
);

    OPECODE           dec_op;
    logic [IMM_W-1:0] dec_imm;

    logic             o_vld, s_vld;
    OPECODE           o_op, s_op;
    logic [IMM_W-1:0] o_imm, s_imm;

    logic             blk;
    logic             in_hs, out_hs;

    // Combinational decode of the incoming word.
    always_comb begin
        dec_imm = in_insn[IMM_W-1:0];
        dec_op  = INVALID;
        case (in_insn[IMM_W+3:IMM_W])
            4'b0000: dec_op = ADD_A_IMM;
            4'b0101: dec_op = ADD_B_IMM;
            4'b0011: dec_op = MOV_A_IMM;
            4'b0111: dec_op = MOV_B_IMM;
            4'b0001: dec_op = MOV_A_B;
            4'b0100: dec_op = MOV_B_A;
            4'b1111: dec_op = JMP_IMM;
            4'b1110: dec_op = JNC_IMM;
            4'b0010: dec_op = IN_A;
            4'b0110: dec_op = IN_B;
            4'b1001: dec_op = OUT_B;
            4'b1011: dec_op = OUT_IMM;
            default: dec_op = INVALID;
        endcase
    end

`ifdef TD4_DECODE_TRAP_EN
    assign blk = trap;
`else
    assign blk = 1'b0;
`endif

    // Skid full means two words are held; refuse more until it drains.
    assign in_ready   = !s_vld && !blk;
    assign in_hs      = in_valid && in_ready;
    assign out_hs     = o_vld && out_ready;

    assign out_valid  = o_vld;
    assign out_opcode = o_op;
    assign out_imm    = o_imm;

    // Output and skid registers. in_hs and (out_hs && s_vld) are mutually
    // exclusive because in_ready is low whenever the skid is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld <= 1'b0;
            o_op  <= INVALID;
            o_imm <= '0;
            s_vld <= 1'b0;
            s_op  <= INVALID;
            s_imm <= '0;
        end else if (flush) begin
            o_vld <= 1'b0;
            s_vld <= 1'b0;
        end else if (out_hs && s_vld) begin
            o_op  <= s_op;
            o_imm <= s_imm;
            s_vld <= 1'b0;
        end else if (in_hs && (!o_vld || out_ready)) begin
            o_vld <= 1'b1;
            o_op  <= dec_op;
            o_imm <= dec_imm;
        end else if (in_hs) begin
            s_vld <= 1'b1;
            s_op  <= dec_op;
            s_imm <= dec_imm;
        end else if (out_hs) begin
            o_vld <= 1'b0;
        end
    end

    // Counters see every output handshake, including one in a flush cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            insn_count    <= '0;
            illegal_count <= '0;
        end else if (out_hs) begin
            if (insn_count != '1)
                insn_count <= insn_count + 1'b1;
            if (o_op == INVALID && illegal_count != '1)
                illegal_count <= illegal_count + 1'b1;
        end
    end

`ifdef TD4_DECODE_TRAP_EN
    // The trapping instruction itself is still stored and delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trap <= 1'b0;
        else if (flush)
            trap <= 1'b0;
        else if (in_hs && dec_op == INVALID)
            trap <= 1'b1;
        else if (trap_clr)
            trap <= 1'b0;
    end
`endif

endmodule
